// File: rtl/mem_fill_responder_pkg.sv
// Shared types and constants for the cache-fill responder.
// Used by the interface, the delay line and the top.
package mem_fill_pkg;
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    localparam int BLOCK_WORDS = 8;
    localparam int OFF_W       = 3;
    localparam int AW          = 16;
    localparam int DW          = 16;
endpackage

// File: rtl/mem_fill_responder_if.sv
// Request/response/storage bundle for mem_fill_responder.
// slave = responder side, master = requester + storage side.
interface mem_fill_responder_if;
    import mem_fill_pkg::*;

    logic          req_valid;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          rsp_last;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_wr;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last,
        output busy, mem_addr, mem_wdata, mem_wr
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last,
        input  busy, mem_addr, mem_wdata, mem_wr
    );
endinterface

// File: rtl/mem_fill_responder_fill_delay_line.sv
// LATENCY-deep shift pipeline for issued words (valid/data/addr/last).
// Data/addr stages only load behind a valid word, so outputs hold when idle.
module fill_delay_line #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic [15:0] in_addr,
    input  logic        in_last,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [15:0] out_addr,
    output logic        out_last
);
    logic [LATENCY-1:0] v;
    logic [LATENCY-1:0] l;
    logic [15:0]        d [LATENCY];
    logic [15:0]        a [LATENCY];

    // Shift every stage each cycle; clear the whole line on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            l <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                d[i] <= '0;
                a[i] <= '0;
            end
        end else begin
            v[0] <= in_valid;
            l[0] <= in_valid & in_last;
            if (in_valid) begin
                d[0] <= in_data;
                a[0] <= in_addr;
            end
            for (int i = 1; i < LATENCY; i++) begin
                v[i] <= v[i-1];
                l[i] <= l[i-1];
                if (v[i-1]) begin
                    d[i] <= d[i-1];
                    a[i] <= a[i-1];
                end
            end
        end
    end

    assign out_valid = v[LATENCY-1];
    assign out_last  = l[LATENCY-1];
    assign out_data  = d[LATENCY-1];
    assign out_addr  = a[LATENCY-1];
endmodule

// File: rtl/mem_fill_responder.sv
// Cache-block fill responder: single-word writes, 8-word block reads.
// MEM_FILL_CRITICAL_WORD_FIRST_EN: start the block at the requested word.
module mem_fill_responder #(
    parameter int LATENCY     = 4,
    parameter int BLOCK_WORDS = mem_fill_pkg::BLOCK_WORDS
) (
    input logic                 clk,
    input logic                 rst_n,
    mem_fill_responder_if.slave bus
);
    import mem_fill_pkg::*;

    localparam logic [OFF_W-1:0] LAST_K = OFF_W'(BLOCK_WORDS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      base;
    logic [OFF_W-1:0] start;
    logic [OFF_W-1:0] cnt;
    logic [OFF_W-1:0] off;
    logic [15:0]      issue_addr;
    logic             accept;
    logic             issuing;
    logic             dl_valid;
    logic             dl_last;
    logic [15:0]      dl_data;
    logic [15:0]      dl_addr;

    assign accept     = bus.req_valid & bus.req_ready;
    assign issuing    = (state == ISSUE);
    assign off        = start + cnt;
    assign issue_addr = base + 16'({off, 1'b0});

    // Next-state: read accept -> issue block -> drain until last word out.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept && !bus.req_wr) state_nxt = ISSUE;
            ISSUE:   if (cnt == LAST_K) state_nxt = DRAIN;
            DRAIN:   if (dl_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Block base, starting word and issue counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base  <= '0;
            start <= '0;
            cnt   <= '0;
        end else if (accept && !bus.req_wr) begin
            base <= {bus.req_addr[15:4], 4'h0};
`ifdef MEM_FILL_CRITICAL_WORD_FIRST_EN
            start <= bus.req_addr[3:1];
`else
            start <= '0;
`endif
            cnt <= '0;
        end else if (issuing) begin
            cnt <= cnt + 1'b1;
        end
    end

    fill_delay_line #(
        .LATENCY (LATENCY)
    ) u_dl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issuing),
        .in_data   (bus.mem_rdata),
        .in_addr   (issue_addr),
        .in_last   (cnt == LAST_K),
        .out_valid (dl_valid),
        .out_data  (dl_data),
        .out_addr  (dl_addr),
        .out_last  (dl_last)
    );

    assign bus.req_ready = rst_n & (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.mem_wr    = accept & bus.req_wr;
    assign bus.mem_addr  = issuing ? issue_addr : bus.req_addr;
    assign bus.mem_wdata = bus.req_wdata;
    assign bus.rsp_valid = dl_valid;
    assign bus.rsp_last  = dl_last;
    assign bus.rsp_data  = dl_data;
    assign bus.rsp_addr  = dl_addr;
endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed + random bench for mem_fill_responder.
// Reference model: flat word array and per-block expected response list.
module tb_mem_fill_responder;
    localparam int L  = 4;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   fails = 0;

    mem_fill_responder_if bus ();

    mem_fill_responder #(
        .LATENCY     (L),
        .BLOCK_WORDS (BW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] ram     [32768];
    logic [15:0] ref_mem [32768];

    assign bus.mem_rdata = ram[bus.mem_addr[15:1]];

    // Storage array written by the DUT's write strobe.
    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_addr[15:1]] <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        chk("wr_ready", 16'(bus.req_ready), 16'd1);
        chk("wr_strobe", 16'(bus.mem_wr), 16'd1);
        chk("wr_addr", bus.mem_addr, a);
        chk("wr_data", bus.mem_wdata, d);
        ref_mem[a[15:1]] = d;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        @(negedge clk);
        chk("wr_strobe_off", 16'(bus.mem_wr), 16'd0);
        chk("wr_no_rsp", 16'(bus.rsp_valid), 16'd0);
        @(posedge clk);
        #1;
    endtask

    // Issue (or continue) a block read and check every following cycle.
    task automatic run_read(input logic [15:0] a, input bit hold,
                            input bit accepted);
        logic [15:0] ea [BW];
        logic [15:0] ed [BW];
        int          st;
        int          k;
        st = 0;
`ifdef MEM_FILL_CRITICAL_WORD_FIRST_EN
        st = int'(a[3:1]);
`endif
        for (int i = 0; i < BW; i++) begin
            ea[i] = (a & 16'hFFF0) + 16'(((st + i) % BW) * 2);
            ed[i] = ref_mem[ea[i][15:1]];
        end
        if (accepted) begin
            bus.req_valid = 1'b0;
        end else begin
            bus.req_valid = 1'b1;
            bus.req_wr    = 1'b0;
            bus.req_addr  = a;
            bus.req_wdata = 16'($urandom);
            @(negedge clk);
            chk("rd_ready", 16'(bus.req_ready), 16'd1);
            chk("rd_no_wr", 16'(bus.mem_wr), 16'd0);
            @(posedge clk);
            #1;
            bus.req_valid = hold;
        end
        for (int n = 1; n <= L + BW + 1; n++) begin
            @(negedge clk);
            if (n <= L + BW) begin
                chk("busy_ready", 16'(bus.req_ready), 16'd0);
                chk("busy", 16'(bus.busy), 16'd1);
                chk("rsp_valid", 16'(bus.rsp_valid), 16'(n >= L + 1));
                if (n >= L + 1) begin
                    k = n - L - 1;
                    chk("rsp_addr", bus.rsp_addr, ea[k]);
                    chk("rsp_data", bus.rsp_data, ed[k]);
                    chk("rsp_last", 16'(bus.rsp_last), 16'(k == BW - 1));
                end
            end else begin
                chk("idle_ready", 16'(bus.req_ready), 16'd1);
                chk("idle_busy", 16'(bus.busy), 16'd0);
                chk("idle_valid", 16'(bus.rsp_valid), 16'd0);
                chk("hold_addr", bus.rsp_addr, ea[BW-1]);
                chk("hold_data", bus.rsp_data, ed[BW-1]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, 16'(bus.rsp_valid), 16'd0);
        chk({tag, "_last"}, 16'(bus.rsp_last), 16'd0);
        chk({tag, "_busy"}, 16'(bus.busy), 16'd0);
        chk({tag, "_data"}, bus.rsp_data, 16'd0);
        chk({tag, "_addr"}, bus.rsp_addr, 16'd0);
        chk({tag, "_memwr"}, 16'(bus.mem_wr), 16'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rd;
        for (int i = 0; i < 32768; i++) begin
            ram[i]     = 16'($urandom);
            ref_mem[i] = ram[i];
        end
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        #3;
        check_reset_vals("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_read(16'h1234, 1'b0, 1'b0);
        do_write(16'h0040, 16'hBEEF);
        run_read(16'h0040, 1'b0, 1'b0);
        chk("first_beef", ref_mem[16'h0020], 16'hBEEF);
        run_read(16'h1236, 1'b0, 1'b0);
        run_read(16'hFFFF, 1'b0, 1'b0);
        run_read(16'h2222, 1'b1, 1'b0);
        run_read(16'h2222, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rd = 16'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                do_write(ra, rd);
                run_read(ra ^ 16'(4 * $urandom_range(3, 0)), 1'b0, 1'b0);
            end else begin
                run_read(ra, 1'b0, 1'b0);
            end
        end

        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 16'h3456;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        @(negedge clk);
        check_reset_vals("arst_hold");
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("post_rst_valid", 16'(bus.rsp_valid), 16'd0);
            chk("post_rst_busy", 16'(bus.busy), 16'd0);
        end
        @(posedge clk);
        #1;
        run_read(16'h5678, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
